// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_seq slice.
//   - op-code encodings (OP_ADD .. OP_ASR)
//   - bit positions inside the flags word {P, C, S, Z}
//   - state encoding of the multiply sequencer
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_INC = 4'b0110;
    localparam logic [3:0] OP_DEC = 4'b0111;
    localparam logic [3:0] OP_RAL = 4'b1000;
    localparam logic [3:0] OP_RAR = 4'b1001;
    localparam logic [3:0] OP_PSA = 4'b1010;
    localparam logic [3:0] OP_PSB = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_SHL = 4'b1101;
    localparam logic [3:0] OP_SHR = 4'b1110;
    localparam logic [3:0] OP_ASR = 4'b1111;

    localparam int FLG_Z = 0;
    localparam int FLG_S = 1;
    localparam int FLG_C = 2;
    localparam int FLG_P = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational datapath for every single-cycle ALU operation.
// Ports:
//   op   [3:0]       operation code (alu_pkg::OP_*)
//   a, b [WIDTH-1:0] operands; b[SHW-1:0] is the shift amount
//   cin              carry/borrow in
//   res  [WIDTH:0]   {cout, result}; zero for OP_MUL (the multiplier lives in alu_seq)
module alu_core #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   res
);
    import alu_pkg::*;

    logic [SHW-1:0]      amt;
    logic [WIDTH:0]      one_w;
    logic [WIDTH:0]      cin_w;
    logic [WIDTH:0]      sh;
    logic signed [WIDTH:0] sh_s;

    assign amt   = b[SHW-1:0];
    assign one_w = {{WIDTH{1'b0}}, 1'b1};
    assign cin_w = {{WIDTH{1'b0}}, cin};

    always_comb begin
        res  = '0;
        sh   = '0;
        sh_s = '0;
        case (op)
            // Bit WIDTH of a two's-complement difference is the borrow.
            OP_ADD: res = {1'b0, a} + {1'b0, b} + cin_w;
            OP_SUB: res = {1'b0, a} - {1'b0, b} - cin_w;
            OP_AND: res = {1'b0, a & b};
            OP_OR:  res = {1'b0, a | b};
            OP_XOR: res = {1'b0, a ^ b};
            OP_NOT: res = {1'b0, ~a};
            OP_INC: res = {1'b0, a} + one_w;
            OP_DEC: res = {1'b0, a} - one_w;
            OP_RAL: res = {a, cin};
            OP_RAR: res = {a[0], cin, a[WIDTH-1:1]};
            OP_PSA: res = {1'b0, a};
            OP_PSB: res = {1'b0, b};
            OP_SHL: res = {1'b0, a} << amt;
            // Right shifts run one guard bit below the LSB; whatever lands
            // there is the last bit shifted out (0 when amt is 0).
            OP_SHR: begin
                sh  = {a, 1'b0} >> amt;
                res = {sh[0], sh[WIDTH:1]};
            end
            OP_ASR: begin
                sh_s = $signed({a, 1'b0}) >>> amt;
                sh   = sh_s;
                res  = {sh[0], sh[WIDTH:1]};
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready request handshake and a flags
// word {P, C, S, Z} registered alongside every result.
// Optional feature macro: ALU_MUL_EN builds the iterative shift-add
// multiplier and its MUL state; without it op 1100 returns zero in one cycle
// and in_ready is constantly 1.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready request handshake (accept when both high)
//   op, a, b, cin     operation and operands, captured at the accept edge
//   out_valid         one-cycle pulse when out/out_hi/cout/flags update
//   out, out_hi       result (low half, high half of MUL product)
//   cout              carry/borrow/shift-out
//   flags             {P, C, S, Z} derived from the registered result
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             cout,
    output logic [3:0]       flags
);
    import alu_pkg::*;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] lo,
                                              input logic [WIDTH-1:0] hi,
                                              input logic c,
                                              input logic s);
        logic [3:0] f;
        f        = '0;
        f[FLG_Z] = ({hi, lo} == '0);
        f[FLG_S] = s;
        f[FLG_C] = c;
        f[FLG_P] = ~^lo;
        return f;
    endfunction

    logic             accept;
    logic [WIDTH:0]   core_res;
    logic             load;
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH-1:0] nxt_hi;
    logic             nxt_c;
    logic             nxt_s;

    assign accept = in_valid && in_ready;

    alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
        .op  (op),
        .a   (a),
        .b   (b),
        .cin (cin),
        .res (core_res)
    );

`ifdef ALU_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t               state_p1, state_d;
    logic [CW-1:0]        cnt_p1;
    logic [2*WIDTH-1:0]   prod_p1;
    logic [WIDTH-1:0]     mcand_p1;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_nxt;
    logic                 mul_last;

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole product register right; the multiplier
    // bits drain out of the bottom as the product fills in from the top.
    assign mul_sum  = {1'b0, prod_p1[2*WIDTH-1:WIDTH]}
                    + (prod_p1[0] ? {1'b0, mcand_p1} : '0);
    assign prod_nxt = {mul_sum, prod_p1[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1 <= ST_IDLE;
            cnt_p1   <= '0;
        end else begin
            state_p1 <= state_d;
            if (state_p1 == ST_MUL) cnt_p1 <= cnt_p1 + 1'b1;
            else                    cnt_p1 <= '0;
        end
    end

    always_comb begin
        state_d  = state_p1;
        in_ready = (state_p1 == ST_IDLE);
        mul_last = 1'b0;
        case (state_p1)
            ST_IDLE: if (accept && op == OP_MUL) state_d = ST_MUL;
            ST_MUL: begin
                if (cnt_p1 == CW'(WIDTH - 1)) begin
                    mul_last = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Multiplier working registers: pure datapath, no reset needed since
    // they are always loaded at accept before being used.
    always_ff @(posedge clk) begin
        if (accept && op == OP_MUL) begin
            prod_p1  <= {{WIDTH{1'b0}}, b};
            mcand_p1 <= a;
        end else if (state_p1 == ST_MUL) begin
            prod_p1  <= prod_nxt;
        end
    end

    always_comb begin
        load   = accept && (op != OP_MUL);
        nxt_lo = core_res[WIDTH-1:0];
        nxt_hi = '0;
        nxt_c  = core_res[WIDTH];
        nxt_s  = core_res[WIDTH-1];
        if (mul_last) begin
            load   = 1'b1;
            nxt_lo = prod_nxt[WIDTH-1:0];
            nxt_hi = prod_nxt[2*WIDTH-1:WIDTH];
            nxt_c  = (prod_nxt[2*WIDTH-1:WIDTH] != '0);
            nxt_s  = prod_nxt[2*WIDTH-1];
        end
    end
`else
    assign in_ready = 1'b1;

    // alu_core yields zero for op 1100, giving the fixed Z=1/P=1 result.
    always_comb begin
        load   = accept;
        nxt_lo = core_res[WIDTH-1:0];
        nxt_hi = '0;
        nxt_c  = core_res[WIDTH];
        nxt_s  = core_res[WIDTH-1];
    end
`endif

    // Output stage: result, carry and flags registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_hi    <= '0;
            cout      <= 1'b0;
            flags     <= '0;
        end else begin
            out_valid <= load;
            if (load) begin
                out    <= nxt_lo;
                out_hi <= nxt_hi;
                cout   <= nxt_c;
                flags  <= make_flags(nxt_lo, nxt_hi, nxt_c, nxt_s);
            end
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the SAP-2 combinational ALU. It is WIDTH bits wide and uses a valid/ready input handshake. A registered flags word (Z, S, C, P) travels with each result. It adds barrel shifts and an iterative unsigned multiply, which makes some operations multi-cycle. It sits between the accumulator/TMP registers and the bus/flag register of the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>= 4)
SHW, $clog2(WIDTH), width of the shift-amount field taken from b

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  high when idle and able to accept a request
op  in  4  operation code
a  in  WIDTH  operand A
b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount
cin  in  1  carry/borrow in
out_valid  out  1  one-cycle pulse; result and flags are updated
out  out  WIDTH  result, low half for MUL
out_hi  out  WIDTH  high half of the MUL product; 0 for all other ops
cout  out  1  carry/borrow/shift-out bit
flags  out  4  {P, C, S, Z}: even parity of out, cout, out[WIDTH-1], out==0

Behaviour:
- Reset (async, any time, including mid-MUL): state goes to IDLE; in_ready=1; out_valid=0; out, out_hi, cout and flags all go to 0. An in-flight MUL is discarded with no out_valid.
- Accept: a request is accepted when in_valid && in_ready are both high at a rising edge. op, a, b and cin are captured at that edge. in_valid while in_ready=0 is ignored; it is not queued.
- Single-cycle ops (every op except MUL): the result is registered at the accepting edge. out_valid is high for exactly the following cycle. in_ready stays 1, so back-to-back requests produce one result per cycle.
- Op codes (arithmetic in WIDTH+1 bits; bit WIDTH is cout):
  - 0000 ADD a+b+cin
  - 0001 SUB a-b-cin; cout is the borrow, i.e. bit WIDTH of the two's-complement difference
  - 0010 AND, 0011 OR, 0100 XOR: cout=0
  - 0101 NOT a: cout=0
  - 0110 INC a+1
  - 0111 DEC a-1: cout follows the same borrow rule as SUB
  - 1000 RAL {cout,out} = {a, cin}
  - 1001 RAR {cout,out} = {a[0], cin, a[WIDTH-1:1]}
  - 1010 PASS a, 1011 PASS b: cout=0
  - 1100 MUL: unsigned a*b
  - 1101 SHL: logical left shift of a by amt
  - 1110 SHR: logical right shift of a by amt
  - 1111 ASR: arithmetic right shift of a by amt
- Shift rules: amt = b[SHW-1:0]. cout = last bit shifted out. amt=0 gives out=a and cout=0.
- MUL FSM, states IDLE -> MUL -> IDLE:
  - On accept, go to MUL and drop in_ready. Shift-add one multiplier bit per cycle for WIDTH cycles.
  - The last iteration registers {out_hi,out}, and out_valid pulses the next cycle. Result latency is WIDTH cycles after the accept edge; in_ready returns to 1 in the out_valid cycle.
  - cin is ignored.
  - MUL flags: Z = full 2*WIDTH product is 0; S = product MSB; C = cout = (out_hi != 0); P = parity of out.
- Hold: out, out_hi, cout and flags keep their values until the next result, or until reset.
- Flags are computed from the registered result, never from operands.

Optional Feature:
ALU_MUL_EN
- Defined: MUL behaves as described above, including the MUL state.
- Undefined: no multiplier and no MUL state are built. Op 1100 is a single-cycle op that returns out=0, out_hi=0, cout=0 and flags={P=1,C=0,S=0,Z=1}. in_ready is tied to 1.

Decomposition:
- Package alu_pkg holds:
  - op-code localparams: OP_ADD … OP_ASR
  - flag bit indices: FLG_Z=0, FLG_S=1, FLG_C=2, FLG_P=3
  - FSM state encodings: ST_IDLE, ST_MUL
- Sub-module alu_core: purely combinational WIDTH-parametrised logic for all single-cycle ops, producing {cout, result}. alu_seq owns the handshake, FSM, multiplier datapath and output/flag registers.

Test Plan:
- Reset mid-operation: WIDTH=8; accept MUL a=0xFF b=0xFF, assert rst at cycle 3 -> out_valid never pulses; out=0, flags=0, in_ready=1 during and after reset.
- ADD carry: ADD a=0xFF b=0x01 cin=0 -> next cycle out_valid=1, out=0x00, cout=1, flags={P=1,C=1,S=0,Z=1}.
- SUB borrow: SUB a=0x05 b=0x07 cin=0 -> out=0xFE, cout=1, S=1, Z=0, P=0.
- Back-to-back single-cycle ops: in_valid held high with INC a=0x7F then RAR a=0x01 cin=1 -> out_valid high on two consecutive cycles; first out=0x80 (S=1, cout=0); second out=0x80, cout=1.
- MUL: MUL a=0xFF b=0xFF -> in_ready low for 8 cycles; out_valid 8 cycles after accept with out_hi=0xFE, out=0x01, cout=1, Z=0, S=1. In_valid pulsed while busy is ignored.
- Shifts: SHL a=0x81 b=0x01 -> out=0x02, cout=1. ASR a=0x80 b=0x03 -> out=0xF0, cout=0. SHR with b=0x08 (amt=0) -> out=a, cout=0.
